// File: rtl/fe25519_pkg.sv
// -----------------------------------------------------------------------------
// fe25519_pkg
// Shared widths, the field prime and the FSM state encoding for the
// GF(2^255-19) digit-serial multiplier front end.
// -----------------------------------------------------------------------------
package fe25519_pkg;

    localparam int FE_W   = 255;
    localparam int PROD_W = 512;

    // p = 2^255 - 19, written as all-ones minus 18 to avoid a long hex literal
    localparam logic [FE_W-1:0] P = {FE_W{1'b1}} - FE_W'(18);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        REQ  = 2'd2,
        WAIT = 2'd3
    } fe_mul_state_t;

endpackage

// File: rtl/fe_mac_digit.sv
// -----------------------------------------------------------------------------
// fe_mac_digit
// One digit step of the MSB-first shift-and-add multiplier:
//   sum_o = (acc_i << DIGIT_W) + x_i * digit_i
// Kept in its own module so the adder/multiplier path can be retimed
// independently for each DIGIT_W.
// Ports:
//   acc_i    PROD_W   running accumulator
//   x_i      FE_W     multiplicand
//   digit_i  DIGIT_W  current multiplier digit
//   sum_o    PROD_W   next accumulator value
// -----------------------------------------------------------------------------
module fe_mac_digit
    import fe25519_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [PROD_W-1:0]  acc_i,
    input  logic [FE_W-1:0]    x_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [PROD_W-1:0]  sum_o
);

    localparam int PP_W = FE_W + DIGIT_W;

    logic [PP_W-1:0] pp;

    // Both operands widened to the partial-product width so the multiply
    // is evaluated at full precision.
    assign pp    = {{DIGIT_W{1'b0}}, x_i} * {{FE_W{1'b0}}, digit_i};
    assign sum_o = (acc_i << DIGIT_W) + {{(PROD_W - PP_W){1'b0}}, pp};

endmodule

// File: rtl/fe_mul_serial.sv
// -----------------------------------------------------------------------------
// fe_mul_serial
// Digit-serial GF(2^255-19) multiplier front end. Forms the 510-bit product
// X*Y (zero-extended to 512 bits) DIGIT_W bits of Y per cycle, MSB first,
// hands it to the serial_modulo reducer and returns the reduced result.
//
// Optional build macro FE_MUL_SQR_EN: adds input sqr; when set with start
// the multiplier operand is taken from X (squaring), Y is ignored.
//
// Ports:
//   clk, reset_n      clock / async active-low reset
//   start             request, only accepted in IDLE
//   X, Y              255-bit operands, latched on accepted start
//   sqr               (FE_MUL_SQR_EN only) square X
//   busy              high whenever not IDLE
//   result            reduced product, held until next done
//   done              one-cycle completion pulse
//   red_start, red_A  request and 512-bit product to the reducer
//   red_result        reducer output
//   red_done          reducer completion pulse
//
// state | meaning
// IDLE  | waiting for start
// MUL   | NDIG shift-and-add digit cycles
// REQ   | load red_A, raise red_start
// WAIT  | waiting for red_done
// -----------------------------------------------------------------------------
module fe_mul_serial
    import fe25519_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [FE_W-1:0]   X,
    input  logic [FE_W-1:0]   Y,
`ifdef FE_MUL_SQR_EN
    input  logic              sqr,
`endif
    output logic              busy,
    output logic [FE_W-1:0]   result,
    output logic              done,
    output logic              red_start,
    output logic [PROD_W-1:0] red_A,
    input  logic [FE_W-1:0]   red_result,
    input  logic              red_done
);

    localparam int YSH_W = FE_W + 1;
    localparam int NDIG  = YSH_W / DIGIT_W;
    localparam int CNT_W = $clog2(NDIG);

    fe_mul_state_t     state_q;
    logic [FE_W-1:0]   xr_q;
    logic [YSH_W-1:0]  ysh_q;
    logic [PROD_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PROD_W-1:0] red_a_q;
    logic              red_start_q;
    logic [FE_W-1:0]   result_q;
    logic              done_q;

    logic [PROD_W-1:0] acc_d;
    logic [FE_W-1:0]   yop_d;

`ifdef FE_MUL_SQR_EN
    assign yop_d = sqr ? X : Y;
`else
    assign yop_d = Y;
`endif

    fe_mac_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_mac (
        .acc_i   (acc_q),
        .x_i     (xr_q),
        .digit_i (ysh_q[YSH_W-1 -: DIGIT_W]),
        .sum_o   (acc_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            xr_q        <= '0;
            ysh_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            red_a_q     <= '0;
            red_start_q <= 1'b0;
            result_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            red_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        xr_q    <= X;
                        ysh_q   <= {1'b0, yop_d};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    ysh_q <= ysh_q << DIGIT_W;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NDIG - 1)) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    red_a_q     <= acc_q;
                    red_start_q <= 1'b1;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (red_done) begin
                        result_q <= red_result;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign done      = done_q;
    assign red_start = red_start_q;
    assign red_A     = red_a_q;

endmodule

// File: tb/tb_fe_mul_serial.sv
module tb_fe_mul_serial;
    import fe25519_pkg::*;

    localparam int DIGIT_W = 4;
    localparam int NDIG    = 256 / DIGIT_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              sqr = 1'b0;
    logic [FE_W-1:0]   X = '0;
    logic [FE_W-1:0]   Y = '0;
    logic              busy;
    logic [FE_W-1:0]   result;
    logic              done;
    logic              red_start;
    logic [PROD_W-1:0] red_A;
    logic [FE_W-1:0]   red_result;
    logic              red_done;
    logic              red_done_m;
    logic              inj_done = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign red_done = red_done_m | inj_done;

    fe_mul_serial #(
        .DIGIT_W (DIGIT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .X          (X),
        .Y          (Y),
`ifdef FE_MUL_SQR_EN
        .sqr        (sqr),
`endif
        .busy       (busy),
        .result     (result),
        .done       (done),
        .red_start  (red_start),
        .red_A      (red_A),
        .red_result (red_result),
        .red_done   (red_done)
    );

    // Behavioural reducer: A mod p, 3..10 cycles after red_start is sampled.
    localparam logic [PROD_W-1:0] P512 = {{(PROD_W-FE_W){1'b0}}, P};
    logic [FE_W-1:0] red_val;
    int              red_cnt;
    logic            red_pend;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            red_pend   <= 1'b0;
            red_done_m <= 1'b0;
            red_result <= '0;
            red_val    <= '0;
            red_cnt    <= 0;
        end else begin
            red_done_m <= 1'b0;
            if (red_start) begin
                red_pend <= 1'b1;
                red_val  <= FE_W'(red_A % P512);
                red_cnt  <= int'($urandom_range(9, 2));
            end else if (red_pend) begin
                if (red_cnt == 0) begin
                    red_done_m <= 1'b1;
                    red_result <= red_val;
                    red_pend   <= 1'b0;
                end else begin
                    red_cnt <= red_cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [PROD_W-1:0] obs, input logic [PROD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PROD_W-1:0] mul512(input logic [FE_W-1:0] a, input logic [FE_W-1:0] b);
        return {{(PROD_W-FE_W){1'b0}}, a} * {{(PROD_W-FE_W){1'b0}}, b};
    endfunction

    task automatic run_op(input string tag, input logic [FE_W-1:0] xa, input logic [FE_W-1:0] ya,
                          input logic s, input logic [PROD_W-1:0] exp_a, input logic [FE_W-1:0] exp_r);
        int n;
        int rs_at;
        int rs_cnt;
        int done_at;
        logic [PROD_W-1:0] cap;
        n = 0; rs_at = -1; rs_cnt = 0; done_at = -1; cap = '0;
        @(negedge clk);
        X = xa; Y = ya; sqr = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (done_at < 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (red_start) begin
                rs_cnt++;
                if (rs_at < 0) begin
                    rs_at = n;
                    cap = red_A;
                end
            end
            if (done) done_at = n;
        end
        chk({tag, "_rs_latency"}, PROD_W'(rs_at), PROD_W'(NDIG + 1));
        chk({tag, "_rs_pulses"}, PROD_W'(rs_cnt), PROD_W'(1));
        chk({tag, "_red_A"}, cap, exp_a);
        chk({tag, "_done_seen"}, PROD_W'(done_at >= 0), PROD_W'(1));
        chk({tag, "_red_A_stable"}, red_A, exp_a);
        chk({tag, "_result"}, PROD_W'(result), PROD_W'(exp_r));
        @(posedge clk); #1;
        chk({tag, "_done_width"}, PROD_W'(done), PROD_W'(0));
        chk({tag, "_idle"}, PROD_W'(busy), PROD_W'(0));
    endtask

    initial begin
        logic [FE_W-1:0] pm1;
        int done_cnt;
        int rs_n;
        int n;
        logic saw_done;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", PROD_W'(busy), PROD_W'(0));
        chk("rst_done", PROD_W'(done), PROD_W'(0));
        chk("rst_red_start", PROD_W'(red_start), PROD_W'(0));
        chk("rst_red_A", red_A, PROD_W'(0));
        chk("rst_result", PROD_W'(result), PROD_W'(0));
        @(negedge clk);
        reset_n = 1'b1;

        run_op("t1", FE_W'(2), FE_W'(3), 1'b0, PROD_W'(6), FE_W'(6));

        // stray red_done while IDLE must be ignored
        @(negedge clk); inj_done = 1'b1;
        @(negedge clk); inj_done = 1'b0;
        #1;
        chk("stray_done", PROD_W'(done), PROD_W'(0));
        chk("stray_result", PROD_W'(result), PROD_W'(6));

        pm1 = P - FE_W'(1);
        run_op("t2", pm1, pm1, 1'b0, mul512(pm1, pm1), FE_W'(1));

        run_op("t3", FE_W'(1) << 254, FE_W'(2), 1'b0, PROD_W'(1) << 255, FE_W'(19));

        run_op("t_zero", FE_W'(0), FE_W'(12345), 1'b0, PROD_W'(0), FE_W'(0));

`ifdef FE_MUL_SQR_EN
        run_op("t6", FE_W'(5), FE_W'(7), 1'b1, PROD_W'(25), FE_W'(25));
`else
        run_op("t6", FE_W'(5), FE_W'(7), 1'b1, PROD_W'(35), FE_W'(35));
`endif

        // start held high; operands changed whenever the block is busy
        done_cnt = 0; rs_n = 0;
        sqr = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b1;
            if (busy) begin X = FE_W'(7); Y = FE_W'(11); end
            else      begin X = FE_W'(3); Y = FE_W'(5); end
            @(posedge clk); #1;
            if (red_start) rs_n++;
            if (done) begin
                done_cnt++;
                chk("t4_result", PROD_W'(result), PROD_W'(15));
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("t4_ops", PROD_W'(done_cnt >= 2), PROD_W'(1));
        chk("t4_no_queue", PROD_W'((rs_n - done_cnt) <= 1), PROD_W'(1));
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (done) chk("t4_tail_result", PROD_W'(result), PROD_W'(15));
        end
        chk("t4_drain", PROD_W'(busy), PROD_W'(0));

        // reset during MUL
        @(negedge clk);
        X = FE_W'(9); Y = FE_W'(9); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t5m_busy", PROD_W'(busy), PROD_W'(0));
        chk("t5m_red_A", red_A, PROD_W'(0));
        chk("t5m_result", PROD_W'(result), PROD_W'(0));
        chk("t5m_done", PROD_W'(done), PROD_W'(0));
        chk("t5m_red_start", PROD_W'(red_start), PROD_W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        @(negedge clk); inj_done = 1'b1;
        @(negedge clk); inj_done = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("t5m_no_done", PROD_W'(saw_done), PROD_W'(0));

        // reset during WAIT
        @(negedge clk);
        X = FE_W'(9); Y = FE_W'(9); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!red_start && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5w_reached_wait", red_A, PROD_W'(81));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t5w_busy", PROD_W'(busy), PROD_W'(0));
        chk("t5w_red_A", red_A, PROD_W'(0));
        chk("t5w_red_start", PROD_W'(red_start), PROD_W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        @(negedge clk); inj_done = 1'b1;
        @(negedge clk); inj_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("t5w_no_done", PROD_W'(saw_done), PROD_W'(0));
        chk("t5w_result", PROD_W'(result), PROD_W'(0));

        run_op("t_after_rst", FE_W'(3), FE_W'(4), 1'b0, PROD_W'(12), FE_W'(12));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
